// File: rtl/slice_scheduler_pkg.sv
// Shared types and defaults for the rotating-display slice scheduler.
// Defaults describe the production display; benches may override per instance.
package slice_scheduler_pkg;

  localparam int DEF_ROTATIONAL_RES = 1024;
  localparam int DEF_NUM_ROWS       = 64;
  localparam int RGB_RES            = 9;
  localparam int DEF_PERIOD_W       = 32;
  localparam int DEF_MIN_PERIOD     = 10000;
  localparam int DEF_BRAM_LATENCY   = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_WAIT    = 2'd3
  } sched_state_t;

  typedef logic [1:0][DEF_NUM_ROWS-1:0][RGB_RES-1:0] column_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/slice_scheduler_rotation_timer.sv
// Hall-sensor period measurement and angular slice tick generation.
// Emits a one-cycle tick with the theta that tick belongs to.
module slice_scheduler_rotation_timer
  import slice_scheduler_pkg::*;
#(
  parameter int ROTATIONAL_RES = DEF_ROTATIONAL_RES,
  parameter int PERIOD_W       = DEF_PERIOD_W,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
  localparam int TW            = $clog2(ROTATIONAL_RES)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          hall_in,
  output logic          tick,
  output logic [TW-1:0] tick_theta,
  output logic          spinning
);

  localparam logic [PERIOD_W-1:0] P_MAX = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [TW-1:0]       T_MAX = {TW{1'b1}};

  logic [2:0]          hall_sync;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] slice_cnt;
  logic [TW-1:0]       theta;
  logic                seen_edge;
  logic                rise;
  logic                accept;
  logic                edge_tick;
  logic                step_tick;

  function automatic logic [PERIOD_W-1:0] interval_of(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W-1:0] s;
    s = p >> TW;
    return (s == '0) ? PERIOD_W'(1) : s;
  endfunction

  assign rise   = hall_sync[1] & ~hall_sync[2];
  assign accept = rise && ((period_cnt >= MIN_P) || !seen_edge);

  always_comb begin
    edge_tick  = accept && seen_edge;
    step_tick  = spinning && (slice_cnt == '0) && (theta != T_MAX);
    tick       = edge_tick || step_tick;
    tick_theta = edge_tick ? '0 : theta + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hall_sync  <= '0;
      period_cnt <= '0;
      period     <= '0;
      slice_cnt  <= '0;
      theta      <= '0;
      seen_edge  <= 1'b0;
      spinning   <= 1'b0;
    end else begin
      hall_sync  <= {hall_sync[1:0], hall_in};
      period_cnt <= accept ? '0 : ((period_cnt == P_MAX) ? P_MAX : period_cnt + 1'b1);

      if (accept) begin
        seen_edge <= 1'b1;
        if (seen_edge) begin
          period   <= period_cnt;
          spinning <= 1'b1;
        end
      end else if (period_cnt == P_MAX) begin
        spinning <= 1'b0;
      end

      // Slice timer is a down-counter reloaded with interval-1 at every tick.
      if (edge_tick) begin
        theta     <= '0;
        slice_cnt <= interval_of(period_cnt) - 1'b1;
      end else if (step_tick) begin
        theta     <= theta + 1'b1;
        slice_cnt <= interval_of(period) - 1'b1;
      end else if (slice_cnt != '0) begin
        slice_cnt <= slice_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/slice_scheduler.sv
// Fetches one angular slice from frame BRAM per tick and presents it to the
// HUB75 driver over valid/ready, queueing at most one slice under backpressure.
module slice_scheduler
  import slice_scheduler_pkg::*;
#(
  parameter int ROTATIONAL_RES = DEF_ROTATIONAL_RES,
  parameter int NUM_ROWS       = DEF_NUM_ROWS,
  parameter int PIX_W          = RGB_RES,
  parameter int PERIOD_W       = DEF_PERIOD_W,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
  parameter int BRAM_LATENCY   = DEF_BRAM_LATENCY,
  localparam int TW            = $clog2(ROTATIONAL_RES),
  localparam int RW            = $clog2(NUM_ROWS),
  localparam int AW            = TW + 1 + RW
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  hall_in,
  output logic [AW-1:0]                         mem_addr,
  input  logic [PIX_W-1:0]                      mem_rdata,
  output logic [1:0][NUM_ROWS-1:0][PIX_W-1:0]   column_data,
  output logic [TW-1:0]                         theta_out,
  output logic                                  tvalid,
  input  logic                                  tready,
  output logic                                  spinning,
  output logic [15:0]                           dropped_slices
);

  // state     | meaning
  // S_IDLE    | not spinning or never started; waiting for a tick
  // S_FETCH   | issuing 2*NUM_ROWS reads, then draining the BRAM pipeline
  // S_PRESENT | column held with tvalid=1 until the driver accepts it
  // S_WAIT    | transfer done while spinning; waiting for the next tick

  localparam int IW        = RW + 1;
  localparam int FETCH_LEN = 2 * NUM_ROWS + BRAM_LATENCY;
  localparam int FW        = $clog2(FETCH_LEN);
  localparam logic [FW-1:0] ISSUE_N  = FW'(2 * NUM_ROWS);
  localparam logic [FW-1:0] LAST_CNT = FW'(FETCH_LEN - 1);

  sched_state_t state, state_d;

  logic                              tick;
  logic [TW-1:0]                     tick_theta;
  logic [FW-1:0]                     fetch_cnt;
  logic [TW-1:0]                     theta_lat;
  logic                              pending;
  logic [TW-1:0]                     pend_theta;
  logic                              issue;
  logic                              handshake;
  logic                              start_fetch;
  logic [TW-1:0]                     start_theta;
  logic                              store_pend;
  logic [BRAM_LATENCY-1:0]           pipe_v;
  logic [BRAM_LATENCY-1:0][IW-1:0]   pipe_idx;

  slice_scheduler_rotation_timer #(
    .ROTATIONAL_RES (ROTATIONAL_RES),
    .PERIOD_W       (PERIOD_W),
    .MIN_PERIOD     (MIN_PERIOD)
  ) u_timer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .hall_in    (hall_in),
    .tick       (tick),
    .tick_theta (tick_theta),
    .spinning   (spinning)
  );

  assign tvalid    = (state == S_PRESENT);
  assign theta_out = theta_lat;
  assign handshake = tvalid && tready;
  assign issue     = (state == S_FETCH) && (fetch_cnt < ISSUE_N);
  assign mem_addr  = issue ? {theta_lat, fetch_cnt[IW-1:0]} : '0;

  always_comb begin
    state_d     = state;
    start_fetch = 1'b0;
    start_theta = tick_theta;
    store_pend  = 1'b0;
    case (state)
      S_IDLE, S_WAIT: begin
        if (tick) begin
          state_d     = S_FETCH;
          start_fetch = 1'b1;
        end else if (state == S_WAIT && !spinning) begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        store_pend = tick;
        if (fetch_cnt == LAST_CNT) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (tready) begin
          // A tick coinciding with the handshake is newer than anything pending.
          if (tick) begin
            state_d     = S_FETCH;
            start_fetch = 1'b1;
          end else if (pending) begin
            state_d     = S_FETCH;
            start_fetch = 1'b1;
            start_theta = pend_theta;
          end else begin
            state_d = spinning ? S_WAIT : S_IDLE;
          end
        end else begin
          store_pend = tick;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      fetch_cnt      <= '0;
      theta_lat      <= '0;
      pending        <= 1'b0;
      pend_theta     <= '0;
      dropped_slices <= '0;
      pipe_v         <= '0;
      pipe_idx       <= '0;
      column_data    <= '0;
    end else begin
      state <= state_d;

      if (start_fetch) begin
        theta_lat <= start_theta;
        fetch_cnt <= '0;
      end else if (state == S_FETCH) begin
        fetch_cnt <= fetch_cnt + 1'b1;
      end

      if (handshake) begin
        pending <= 1'b0;
      end else if (store_pend) begin
        pending    <= 1'b1;
        pend_theta <= tick_theta;
        if (pending) dropped_slices <= sat_inc16(dropped_slices);
      end

      pipe_v[0]   <= issue;
      pipe_idx[0] <= fetch_cnt[IW-1:0];
      for (int k = 1; k < BRAM_LATENCY; k++) begin
        pipe_v[k]   <= pipe_v[k-1];
        pipe_idx[k] <= pipe_idx[k-1];
      end

      if (pipe_v[BRAM_LATENCY-1])
        column_data[pipe_idx[BRAM_LATENCY-1][IW-1]][pipe_idx[BRAM_LATENCY-1][RW-1:0]] <= mem_rdata;
    end
  end

endmodule
